// File: rtl/seg_display_scheduler.sv
// Arbitrates the 8-digit seven-segment display between two round-robin frame
// requesters and a preempting error source, with a minimum hold and idle blanking.
module seg_display_scheduler #(
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned IDLE_TIMEOUT = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_a_i,
  input  logic [31:0] numb_a_i,
  input  logic [7:0]  mask_a_i,
  output logic        ack_a_o,
  input  logic        req_b_i,
  input  logic [31:0] numb_b_i,
  input  logic [7:0]  mask_b_i,
  output logic        ack_b_o,
  input  logic        err_in_i,
  input  logic [3:0]  err_code_i,
  output logic [31:0] numb_o,
  output logic [7:0]  mask_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam int HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IdleW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TIMEOUT);

  localparam logic [31:0] BlankNumb = 32'h0;
  localparam logic [7:0]  BlankMask = 8'hFF;
  localparam logic [7:0]  ErrMask   = 8'b0111_1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      numb_q, numb_d;
  logic [7:0]       mask_q, mask_d;
  logic             error_q, error_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             last_b_q, last_b_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  logic any_req;
  logic pick_a;
  logic hold_done;
  logic grant;

  // On a tie, the requester that was not granted last wins.
  assign any_req   = req_a_i | req_b_i;
  assign pick_a    = req_a_i & (~req_b_i | last_b_q);
  assign hold_done = (hold_cnt_q == HoldMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      numb_q     <= BlankNumb;
      mask_q     <= BlankMask;
      error_q    <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      numb_q     <= numb_d;
      mask_q     <= mask_d;
      error_q    <= error_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      last_b_q   <= last_b_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    numb_d     = numb_q;
    mask_d     = mask_q;
    error_d    = error_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    last_b_d   = last_b_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;
    grant      = 1'b0;

    if (err_in_i) begin
      // Error overrides every grant; the error frame follows err_code each cycle.
      state_d    = ERR;
      numb_d     = {4'hE, 24'h0, err_code_i};
      mask_d     = ErrMask;
      error_d    = 1'b1;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          grant = any_req;
        end
        SHOW: begin
          if (!hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end else if (any_req) begin
            grant = 1'b1;
          end else if (IDLE_TIMEOUT != 0) begin
            if (idle_cnt_q == IdleMax) begin
              state_d    = IDLE;
              numb_d     = BlankNumb;
              mask_d     = BlankMask;
              hold_cnt_d = '0;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
        end
        ERR: begin
          // The interrupted frame is dropped; pending requests win from IDLE next.
          state_d = IDLE;
          numb_d  = BlankNumb;
          mask_d  = BlankMask;
          error_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          numb_d  = BlankNumb;
          mask_d  = BlankMask;
          error_d = 1'b0;
        end
      endcase

      if (grant) begin
        state_d    = SHOW;
        numb_d     = pick_a ? numb_a_i : numb_b_i;
        mask_d     = pick_a ? mask_a_i : mask_b_i;
        error_d    = 1'b0;
        ack_a_d    = pick_a;
        ack_b_d    = ~pick_a;
        last_b_d   = ~pick_a;
        hold_cnt_d = '0;
        idle_cnt_d = '0;
      end
    end
  end

  assign numb_o  = numb_q;
  assign mask_o  = mask_q;
  assign error_o = error_q;
  assign ack_a_o = ack_a_q;
  assign ack_b_o = ack_b_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: a timestamp-based display model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_seg_display_scheduler;

  localparam int HOLD = 4;
  localparam int TMO  = 6;

  typedef struct {
    logic        ack_a;
    logic        ack_b;
    logic [31:0] numb;
    logic [7:0]  mask;
    logic        error;
    logic        busy;
  } exp_t;

  typedef enum int {M_BLANK, M_FRAME, M_ERR} mode_t;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic [31:0] numb_a, numb_b;
  logic [7:0]  mask_a, mask_b;
  logic        ack_a, ack_b;
  logic        err_in;
  logic [3:0]  err_code;
  logic [31:0] numb;
  logic [7:0]  mask;
  logic        error;
  logic        busy;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  logic auto_drop   = 1'b0;
  logic random_mode = 1'b0;

  // Reference model state: what is on the display and when it was latched.
  mode_t       m_mode   = M_BLANK;
  int          cyc      = 0;
  int          m_latch  = 0;
  logic        m_last_b = 1'b1;
  logic        m_ack_a  = 1'b0;
  logic        m_ack_b  = 1'b0;
  logic [31:0] m_numb   = 32'h0;
  logic [7:0]  m_mask   = 8'hFF;
  logic [3:0]  m_code   = 4'h0;
  exp_t        m_e;
  exp_t        mon_e;

  seg_display_scheduler #(
    .HOLD_CYCLES (HOLD),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_a_i   (req_a),
    .numb_a_i  (numb_a),
    .mask_a_i  (mask_a),
    .ack_a_o   (ack_a),
    .req_b_i   (req_b),
    .numb_b_i  (numb_b),
    .mask_b_i  (mask_b),
    .ack_b_o   (ack_b),
    .err_in_i  (err_in),
    .err_code_i(err_code),
    .numb_o    (numb),
    .mask_o    (mask),
    .error_o   (error),
    .busy_o    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A frame may be replaced once HOLD edges have elapsed since its latch; with no
  // request it blanks HOLD+TMO edges after the latch.
  always @(posedge clk) begin
    cyc     = cyc + 1;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    if (rst) begin
      m_mode   = M_BLANK;
      m_last_b = 1'b1;
    end else if (err_in) begin
      m_mode = M_ERR;
      m_code = err_code;
    end else if (m_mode == M_ERR) begin
      m_mode = M_BLANK;
    end else if (m_mode == M_BLANK || (cyc - m_latch) >= HOLD) begin
      if (req_a || req_b) begin
        if (req_a && (!req_b || m_last_b)) begin
          m_ack_a  = 1'b1;
          m_numb   = numb_a;
          m_mask   = mask_a;
          m_last_b = 1'b0;
        end else begin
          m_ack_b  = 1'b1;
          m_numb   = numb_b;
          m_mask   = mask_b;
          m_last_b = 1'b1;
        end
        m_mode  = M_FRAME;
        m_latch = cyc;
      end else if (m_mode == M_FRAME && TMO != 0 && (cyc - m_latch) >= HOLD + TMO) begin
        m_mode = M_BLANK;
      end
    end
    m_e.ack_a = m_ack_a;
    m_e.ack_b = m_ack_b;
    case (m_mode)
      M_FRAME: begin
        m_e.numb = m_numb; m_e.mask = m_mask; m_e.error = 1'b0; m_e.busy = 1'b1;
      end
      M_ERR: begin
        m_e.numb = {4'hE, 24'h0, m_code}; m_e.mask = 8'h7E; m_e.error = 1'b1; m_e.busy = 1'b1;
      end
      default: begin
        m_e.numb = 32'h0; m_e.mask = 8'hFF; m_e.error = 1'b0; m_e.busy = 1'b0;
      end
    endcase
    sb_q.push_back(m_e);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL scoreboard at cycle %0d: got no expected entry, expected one", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("ack_a", 32'(ack_a), 32'(mon_e.ack_a));
        checkOutput("ack_b", 32'(ack_b), 32'(mon_e.ack_b));
        checkOutput("numb", numb, mon_e.numb);
        checkOutput("mask", 32'(mask), 32'(mon_e.mask));
        checkOutput("error", 32'(error), 32'(mon_e.error));
        checkOutput("busy", 32'(busy), 32'(mon_e.busy));
        checkOutput("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
      end
    end
  end

  task automatic randomInputs();
    if (!req_a) begin
      if ($urandom_range(0, 3) == 0) begin
        req_a  = 1'b1;
        numb_a = $urandom;
        mask_a = 8'($urandom);
      end
    end else if (m_ack_a && $urandom_range(0, 1) == 0) begin
      req_a = 1'b0;
    end
    if (!req_b) begin
      if ($urandom_range(0, 3) == 0) begin
        req_b  = 1'b1;
        numb_b = $urandom;
        mask_b = 8'($urandom);
      end
    end else if (m_ack_b && $urandom_range(0, 1) == 0) begin
      req_b = 1'b0;
    end
    if (!err_in) err_in = ($urandom_range(0, 39) == 0);
    else         err_in = ($urandom_range(0, 4) != 0);
    err_code = 4'($urandom);
    rst      = ($urandom_range(0, 199) == 0);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (random_mode) begin
        randomInputs();
      end else begin
        if (auto_drop && m_ack_a) req_a = 1'b0;
        if (auto_drop && m_ack_b) req_b = 1'b0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    req_a    = 1'b0;
    req_b    = 1'b0;
    numb_a   = 32'h0;
    numb_b   = 32'h0;
    mask_a   = 8'h00;
    mask_b   = 8'h00;
    err_in   = 1'b0;
    err_code = 4'h0;

    // Reset held with a pending request, then single grant and idle blanking.
    $display("[TB] reset and single grant");
    auto_drop = 1'b1;
    req_a     = 1'b1;
    numb_a    = 32'h12345678;
    mask_a    = 8'h00;
    applyStimulus(3);
    rst = 1'b0;
    applyStimulus(14);

    $display("[TB] round-robin");
    auto_drop = 1'b0;
    numb_a = 32'hAAAA1111; mask_a = 8'h0F;
    numb_b = 32'hBBBB2222; mask_b = 8'hF0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    applyStimulus(20);
    req_a = 1'b0;
    req_b = 1'b0;
    applyStimulus(12);

    $display("[TB] hold guarantee");
    auto_drop = 1'b1;
    numb_a = 32'h00C0FFEE; mask_a = 8'h81;
    req_a  = 1'b1;
    applyStimulus(1);
    numb_b = 32'hDEADBEEF; mask_b = 8'h3C;
    req_b  = 1'b1;
    applyStimulus(16);

    $display("[TB] error preemption");
    numb_a = 32'h13572468; mask_a = 8'h00;
    req_a  = 1'b1;
    applyStimulus(2);
    numb_b   = 32'h24681357; mask_b = 8'h11;
    req_b    = 1'b1;
    err_code = 4'h7;
    err_in   = 1'b1;
    applyStimulus(3);
    err_in = 1'b0;
    applyStimulus(14);

    $display("[TB] simultaneous request and error");
    numb_a   = 32'hFEDCBA98; mask_a = 8'h42;
    req_a    = 1'b1;
    err_code = 4'h3;
    err_in   = 1'b1;
    applyStimulus(5);
    err_in = 1'b0;
    applyStimulus(14);

    $display("[TB] randomized traffic");
    auto_drop   = 1'b0;
    random_mode = 1'b1;
    applyStimulus(3000);
    random_mode = 1'b0;
    rst    = 1'b0;
    err_in = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    applyStimulus(2);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
